// File: rtl/alarm_controller_if.sv
// Alarm controller signal bundle.
// master = time/button source, slave = alarm_controller.
interface alarm_controller_if;
    logic        tick_1hz;
    logic [12:0] time_bcd;
    logic        alarm_en;
    logic        set_mode;
    logic        btn_hour;
    logic        btn_min;
    logic        btn_stop;
    logic        btn_snooze;
    logic [12:0] alarm_bcd;
    logic [1:0]  state;
    logic        buzzer;
    logic        ringing;

    modport master (
        output tick_1hz, time_bcd, alarm_en, set_mode,
        output btn_hour, btn_min, btn_stop, btn_snooze,
        input  alarm_bcd, state, buzzer, ringing
    );

    modport slave (
        input  tick_1hz, time_bcd, alarm_en, set_mode,
        input  btn_hour, btn_min, btn_stop, btn_snooze,
        output alarm_bcd, state, buzzer, ringing
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm clock controller: BCD alarm-time editing, match trigger, ring/snooze FSM.
// Define ALARM_SNOOZE_EN to compile in the SNOOZE state and 300 s snooze timer.
module alarm_controller (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        RINGING  = 2'b10,
        SNOOZE   = 2'b11
    } state_t;

    state_t      state_q, state_n;
    logic [1:0]  hr_t_q, hr_t_n;
    logic [3:0]  hr_u_q, hr_u_n;
    logic [2:0]  mn_t_q, mn_t_n;
    logic [3:0]  mn_u_q, mn_u_n;
    logic [8:0]  cnt_q, cnt_n;
    logic        phase_q, phase_n;
    logic        buzzer_q;
    logic        match, match_d, trigger;

    assign bus.alarm_bcd = {hr_t_q, hr_u_q, mn_t_q, mn_u_q};
    assign bus.state     = state_q;
    assign bus.ringing   = (state_q == RINGING);
    assign bus.buzzer    = buzzer_q;

    // Rising edge of match only, so a held minute rings once.
    assign match   = (bus.time_bcd == bus.alarm_bcd);
    assign trigger = match & ~match_d & ~bus.set_mode;

`ifndef ALARM_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = bus.btn_snooze;
`endif

    always_comb begin
        hr_t_n = hr_t_q;
        hr_u_n = hr_u_q;
        mn_t_n = mn_t_q;
        mn_u_n = mn_u_q;
        if (bus.set_mode && bus.btn_hour) begin
            if (hr_t_q == 2'd2 && hr_u_q == 4'd3) begin
                hr_t_n = 2'd0;
                hr_u_n = 4'd0;
            end else if (hr_u_q == 4'd9) begin
                hr_t_n = hr_t_q + 2'd1;
                hr_u_n = 4'd0;
            end else begin
                hr_u_n = hr_u_q + 4'd1;
            end
        end
        if (bus.set_mode && bus.btn_min) begin
            if (mn_u_q == 4'd9) begin
                mn_u_n = 4'd0;
                mn_t_n = (mn_t_q == 3'd5) ? 3'd0 : mn_t_q + 3'd1;
            end else begin
                mn_u_n = mn_u_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        phase_n = phase_q;
        if (!bus.alarm_en) begin
            state_n = DISARMED;
        end else begin
            unique case (state_q)
                DISARMED: state_n = ARMED;
                ARMED: begin
                    if (trigger) begin
                        state_n = RINGING;
                        cnt_n   = 9'd0;
                        phase_n = 1'b1;
                    end
                end
                RINGING: begin
                    if (bus.btn_stop) begin
                        state_n = ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.btn_snooze) begin
                        state_n = SNOOZE;
                        cnt_n   = 9'd0;
`endif
                    end else if (bus.tick_1hz) begin
                        phase_n = ~phase_q;
                        if (cnt_q == 9'd59) state_n = ARMED;
                        else                cnt_n   = cnt_q + 9'd1;
                    end
                end
                SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                    if (bus.btn_stop) begin
                        state_n = ARMED;
                    end else if (bus.tick_1hz) begin
                        if (cnt_q == 9'd299) begin
                            state_n = RINGING;
                            cnt_n   = 9'd0;
                            phase_n = 1'b1;
                        end else begin
                            cnt_n = cnt_q + 9'd1;
                        end
                    end
`else
                    state_n = DISARMED;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DISARMED;
            hr_t_q   <= 2'd0;
            hr_u_q   <= 4'd0;
            mn_t_q   <= 3'd0;
            mn_u_q   <= 4'd0;
            cnt_q    <= 9'd0;
            phase_q  <= 1'b0;
            buzzer_q <= 1'b0;
            match_d  <= 1'b1;
        end else begin
            state_q  <= state_n;
            hr_t_q   <= hr_t_n;
            hr_u_q   <= hr_u_n;
            mn_t_q   <= mn_t_n;
            mn_u_q   <= mn_u_n;
            cnt_q    <= cnt_n;
            phase_q  <= phase_n;
            buzzer_q <= (state_n == RINGING) && phase_n;
            match_d  <= match;
        end
    end
endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: tick_1hz  input  1  one-clk-wide pulse, once per second, from the 1 Hz divider.
REQ-004 SHALL: time_bcd  input  13  current time {hours_tens[1:0], hours[3:0], minutes_tens[2:0], minutes[3:0]}, as produced by the hours/minutes counter.
REQ-005 SHALL: alarm_en  input  1  level; high arms the alarm.
REQ-006 SHALL: set_mode  input  1  level; high enables alarm-time editing.
REQ-007 SHALL: btn_hour, btn_min  input  1 each  debounced one-clk pulses; each pulse increments the alarm hour or minute.
REQ-008 SHALL: btn_stop, btn_snooze  input  1 each  debounced one-clk pulses.
REQ-009 SHALL: alarm_bcd  output  13  stored alarm time, same packing as time_bcd, for the display mux.
REQ-010 SHALL: state  output  2  FSM state: 00 DISARMED, 01 ARMED, 10 RINGING, 11 SNOOZE.
REQ-011 SHALL: buzzer  output  1  registered buzzer drive.
REQ-012 SHALL: ringing  output  1  high in RINGING, for the LED/DP indicator.

Function
REQ-013 SHALL: with set_mode=1, btn_hour increments the alarm hour in BCD, 23 -> 00; btn_min increments the alarm minute in BCD, 59 -> 00, with no carry into hours.
REQ-014 SHALL: btn_hour and btn_min asserted in the same cycle both take effect; both are ignored when set_mode=0; editing is allowed in any FSM state.
REQ-015 SHALL: match = (time_bcd == alarm_bcd), compared combinationally; match_d is its registered copy.
REQ-016 SHALL: a trigger is match=1 AND match_d=0 AND set_mode=0; a held match never re-triggers within the same minute.
REQ-017 SHALL: alarm_en=0 forces DISARMED on the next edge from any state, with highest priority.
REQ-018 SHALL: DISARMED -> ARMED when alarm_en=1.
REQ-019 SHALL: ARMED -> RINGING on the same edge at which the trigger is sampled.
REQ-020 SHALL: on RINGING entry, clear the 9-bit tick counter; RINGING -> ARMED on btn_stop, or on the 60th tick_1hz counted in RINGING.
REQ-021 SHALL: RINGING -> SNOOZE on btn_snooze (see REQ-029); on SNOOZE entry, clear the tick counter.
REQ-022 SHALL: SNOOZE -> RINGING on the 300th tick_1hz counted in SNOOZE; SNOOZE -> ARMED on btn_stop.
REQ-023 SHALL: btn_stop and btn_snooze in the same cycle: stop wins.
REQ-024 SHALL: in RINGING, a tick_1hz coinciding with btn_stop: btn_stop wins; the counter is not advanced.
REQ-025 SHALL: beep_phase is set to 1 on RINGING entry and toggles on each tick_1hz in RINGING; buzzer = registered (state==RINGING AND beep_phase), so the buzzer sounds on alternate seconds; buzzer=0 in all other states.
REQ-026 SHALL: a trigger occurring in DISARMED, RINGING or SNOOZE is ignored.
REQ-027 SHALL: input time_bcd is not range-checked; an out-of-range value only affects match.

Reset
REQ-028 SHALL: reset asserted (asynchronous, any time including mid-ring) forces:
- alarm_bcd = 00:00
- state = DISARMED
- tick counter = 0
- beep_phase = 0
- buzzer = 0
- ringing = 0
- match_d = 1, so there is no spurious trigger at 00:00 after release.

Configuration
REQ-029 SHALL: macro ALARM_SNOOZE_EN, when defined, compiles in the SNOOZE state, the btn_snooze path and the 300-tick timer; when undefined, btn_snooze is ignored, state 11 is unreachable, and RINGING exits only via btn_stop, the 60-tick timeout or alarm_en=0.

Verification
REQ-030 SHALL: reset; set_mode=1; 7 btn_hour + 30 btn_min pulses -> alarm_bcd = 07:30; 24 further btn_hour pulses -> hour returns to 07; 30 further btn_min pulses -> minute wraps to 00, hour stays 07.
REQ-031 SHALL: alarm 07:30, alarm_en=1, time_bcd steps 07:29 -> 07:30 -> state=RINGING at the next edge; buzzer toggles each tick_1hz; after 60 ticks -> ARMED; time held at 07:30 -> no re-ring.
REQ-032 SHALL: RINGING; btn_stop and btn_snooze in the same cycle -> ARMED, buzzer=0.
REQ-033 SHALL: ALARM_SNOOZE_EN defined; RINGING + btn_snooze -> SNOOZE; 299 ticks -> still SNOOZE; 300th tick -> RINGING; without the macro, the same stimulus -> remains RINGING.
REQ-034 SHALL: RINGING; alarm_en 1 -> 0 -> DISARMED next edge; reset pulse mid-ring -> all outputs at reset values immediately, with no trigger at 00:00 after release.
